// File: rtl/pipe_issue_arbiter.sv
// Round-robin issue controller for the shared 3-stage regfile/ALU pipeline:
// RAW-hazard scoreboard, bubble insertion and response tag tracking.

module pipe_issue_lane (
    input  logic            valid,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [1:0]      sb_vld,
    input  logic [1:0][4:0] sb_rd,
    output logic            eligible,
    output logic            blocked
);
    logic [1:0] hit;

    // r0 is never written, so an rd of zero cannot create a hazard
    always_comb begin
        hit = '0;
        for (int e = 0; e < 2; e++)
            hit[e] = sb_vld[e] && (sb_rd[e] != 5'd0) &&
                     ((rs1 == sb_rd[e]) || (rs2 == sb_rd[e]));
    end

    assign eligible = valid && (hit == 2'b00);
    assign blocked  = valid && (hit != 2'b00);
endmodule

module pipe_issue_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [5*N_REQ-1:0]  req_rs1,
    input  logic [5*N_REQ-1:0]  req_rs2,
    input  logic [5*N_REQ-1:0]  req_rd,
    input  logic [4*N_REQ-1:0]  req_func,
    input  logic [32*N_REQ-1:0] req_addr,
    output logic [4:0]          pl_rs1,
    output logic [4:0]          pl_rs2,
    output logic [4:0]          pl_rd,
    output logic [3:0]          pl_func,
    output logic [31:0]         pl_addr,
    input  logic [31:0]         pl_mem_out,
    output logic                rsp_valid,
    output logic [ID_W-1:0]     rsp_id,
    output logic [31:0]         rsp_data,
    output logic [15:0]         stall_cnt
);
    localparam int STAGES = 3;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  func;
        logic [31:0] addr;
    } issue_t;

    localparam issue_t BUBBLE = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, func: 4'hF, addr: 32'd0};

    issue_t [N_REQ-1:0]         lane_op;
    logic   [N_REQ-1:0]         elig;
    logic   [N_REQ-1:0]         blocked;
    logic   [1:0]               sb_vld;
    logic   [1:0][4:0]          sb_rd;
    logic   [ID_W-1:0]          rr_ptr;
    logic   [ID_W-1:0]          gnt_id;
    logic                       gnt_any;
    logic   [ID_W:0]            idx;
    issue_t                     pl_op;
    logic   [STAGES:1]          vld_pipe;
    logic   [STAGES:1][ID_W-1:0] id_pipe;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign lane_op[i] = '{rs1: req_rs1[5*i +: 5], rs2: req_rs2[5*i +: 5],
                              rd: req_rd[5*i +: 5], func: req_func[4*i +: 4],
                              addr: req_addr[32*i +: 32]};

        pipe_issue_lane u_lane (
            .valid    (req_valid[i]),
            .rs1      (req_rs1[5*i +: 5]),
            .rs2      (req_rs2[5*i +: 5]),
            .sb_vld   (sb_vld),
            .sb_rd    (sb_rd),
            .eligible (elig[i]),
            .blocked  (blocked[i])
        );
    end

    // Scan from rr_ptr; reset suppresses any grant so outputs fall immediately
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N_REQ))
                idx = idx - (ID_W+1)'(N_REQ);
            if (!gnt_any && !reset && elig[idx[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = idx[ID_W-1:0];
            end
        end
    end

    assign req_ready = gnt_any ? (N_REQ'(1) << gnt_id) : '0;
    assign pl_op     = gnt_any ? lane_op[gnt_id] : BUBBLE;
    assign pl_rs1    = pl_op.rs1;
    assign pl_rs2    = pl_op.rs2;
    assign pl_rd     = pl_op.rd;
    assign pl_func   = pl_op.func;
    assign pl_addr   = pl_op.addr;

    assign rsp_valid = vld_pipe[STAGES] && !reset;
    assign rsp_id    = id_pipe[STAGES];
    assign rsp_data  = pl_mem_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            sb_vld    <= '0;
            sb_rd     <= '0;
            vld_pipe  <= '0;
            id_pipe   <= '0;
            stall_cnt <= '0;
        end else begin
            if (gnt_any)
                rr_ptr <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
            sb_vld   <= {sb_vld[0], gnt_any};
            sb_rd    <= {sb_rd[0], pl_op.rd};
            vld_pipe <= {vld_pipe[STAGES-1:1], gnt_any};
            id_pipe  <= {id_pipe[STAGES-1:1], gnt_id};
            if ((|blocked) && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Directed bench for pipe_issue_arbiter with a behavioural 3-stage regfile/ALU
// pipeline model (registers reset to r_k = k+1).

module tb_pipe_issue_arbiter;
    localparam int N = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [5*N-1:0]  req_rs1 = '0, req_rs2 = '0, req_rd = '0;
    logic [4*N-1:0]  req_func = '0;
    logic [32*N-1:0] req_addr = '0;
    logic [4:0]      pl_rs1, pl_rs2, pl_rd;
    logic [3:0]      pl_func;
    logic [31:0]     pl_addr, pl_mem_out;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_data;
    logic [15:0]     stall_cnt;

    int total = 0;
    int bad = 0;

    pipe_issue_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .req_func(req_func), .req_addr(req_addr),
        .pl_rs1(pl_rs1), .pl_rs2(pl_rs2), .pl_rd(pl_rd),
        .pl_func(pl_func), .pl_addr(pl_addr), .pl_mem_out(pl_mem_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .stall_cnt(stall_cnt)
    );

    // Pipeline model: read at issue edge, ALU next, writeback + mem_out on the third
    logic [31:0] regs [32];
    logic [31:0] ex_a, ex_b, mem_val;
    logic [3:0]  ex_func;
    logic [4:0]  ex_rd, mem_rd;

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        case (f)
            4'h0: alu = a + b;
            4'h1: alu = a - b;
            4'h2: alu = a & b;
            4'h3: alu = a | b;
            default: alu = 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) regs[k] <= 32'(k + 1);
            ex_a <= '0; ex_b <= '0; ex_func <= 4'hF; ex_rd <= '0;
            mem_val <= '0; mem_rd <= '0; pl_mem_out <= '0;
        end else begin
            ex_a <= regs[pl_rs1]; ex_b <= regs[pl_rs2]; ex_func <= pl_func; ex_rd <= pl_rd;
            mem_val <= alu(ex_a, ex_b, ex_func); mem_rd <= ex_rd;
            pl_mem_out <= mem_val;
            if (mem_rd != 5'd0) regs[mem_rd] <= mem_val;
        end
    end

    task automatic set_req(input int i, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [3:0] func);
        req_valid[i] = 1'b1;
        req_rs1[5*i +: 5] = rs1;
        req_rs2[5*i +: 5] = rs2;
        req_rd[5*i +: 5] = rd;
        req_func[4*i +: 4] = func;
        req_addr[32*i +: 32] = 32'h1000 + 32'(i);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        set_req(0, 1, 2, 5, 0);
        set_req(3, 3, 4, 9, 0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        total++; if ({pl_rs1, pl_rs2, pl_rd, pl_func} !== {5'd0, 5'd0, 5'd0, 4'hF}) begin bad++; $display("FAIL reset_bubble got=%h/%h/%h/%h exp=0/0/0/f", pl_rs1, pl_rs2, pl_rd, pl_func); end
        total++; if (pl_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", pl_addr); end
        total++; if ({rsp_valid, rsp_id, stall_cnt} !== {1'b0, 2'd0, 16'd0}) begin bad++; $display("FAIL reset_rsp got=%b/%0d/%0d exp=0/0/0", rsp_valid, rsp_id, stall_cnt); end
        req_valid = '0;
        step;
        reset = 1'b0;
    endtask

    task automatic test_single;
        set_req(0, 1, 2, 5, 0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        total++; if ({pl_rs1, pl_rs2, pl_rd, pl_func} !== {5'd1, 5'd2, 5'd5, 4'd0}) begin bad++; $display("FAIL single_pl got=%0d/%0d/%0d/%h exp=1/2/5/0", pl_rs1, pl_rs2, pl_rd, pl_func); end
        total++; if (pl_addr !== 32'h1000) begin bad++; $display("FAIL single_addr got=%h exp=1000", pl_addr); end
        step;
        req_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c < 3) begin
                total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_rsp c=%0d got=%b exp=0", c, rsp_valid); end
            end else begin
                total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 32'd5}) begin bad++; $display("FAIL single_rsp got=%b/%0d/%0d exp=1/0/5", rsp_valid, rsp_id, rsp_data); end
            end
            step;
        end
    endtask

    task automatic test_raw_stall;
        set_req(0, 1, 2, 5, 0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL raw_first got=%b exp=0001", req_ready); end
        step;
        set_req(0, 5, 0, 6, 0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            case (c)
                1, 2: begin
                    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL raw_blocked c=%0d got=%b exp=0000", c, req_ready); end
                    if (c == 1) begin
                        total++; if ({pl_rd, pl_func} !== {5'd0, 4'hF}) begin bad++; $display("FAIL raw_bubble got=%0d/%h exp=0/f", pl_rd, pl_func); end
                    end
                end
                3: begin
                    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL raw_issue got=%b exp=0001", req_ready); end
                    total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 32'd5}) begin bad++; $display("FAIL raw_rsp1 got=%b/%0d/%0d exp=1/0/5", rsp_valid, rsp_id, rsp_data); end
                end
                4, 5: begin
                    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL raw_gap c=%0d got=%b exp=0", c, rsp_valid); end
                    if (c == 5) begin
                        total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL raw_stall_cnt got=%0d exp=2", stall_cnt); end
                    end
                end
                default: begin
                    total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 32'd6}) begin bad++; $display("FAIL raw_rsp2 got=%b/%0d/%0d exp=1/0/6", rsp_valid, rsp_id, rsp_data); end
                end
            endcase
            step;
            if (c == 3) req_valid = '0;
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_rdy;
        logic [1:0] exp_id;
        reset = 1'b1;
        step;
        reset = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            if (k < 8) for (int i = 0; i < N; i++) set_req(i, 1, 2, 5'(10 + i), 0);
            else req_valid = '0;
            @(negedge clk);
            if (k < 8) begin
                exp_rdy = 4'b0001 << (k % 4);
                total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
                total++; if (pl_rd !== 5'(10 + k % 4)) begin bad++; $display("FAIL rr_rd k=%0d got=%0d exp=%0d", k, pl_rd, 10 + k % 4); end
            end
            if (k >= 3) begin
                exp_id = 2'((k - 3) % 4);
                total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, exp_id, 32'd5}) begin bad++; $display("FAIL rr_rsp k=%0d got=%b/%0d/%0d exp=1/%0d/5", k, rsp_valid, rsp_id, rsp_data, exp_id); end
            end
            step;
        end
        req_valid = '0;
    endtask

    task automatic test_hazard_skip;
        set_req(0, 1, 2, 7, 0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL skip_first got=%b exp=0001", req_ready); end
        step;
        req_valid = '0;
        set_req(1, 7, 1, 8, 0);
        set_req(2, 1, 2, 9, 0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL skip_grant2 got=%b exp=0100", req_ready); end
        step;
        req_valid[2] = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL skip_wait got=%b exp=0000", req_ready); end
        step;
        @(negedge clk);
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL skip_grant1 got=%b exp=0010", req_ready); end
        total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 32'd5}) begin bad++; $display("FAIL skip_rsp0 got=%b/%0d/%0d exp=1/0/5", rsp_valid, rsp_id, rsp_data); end
        total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL skip_stall_cnt got=%0d exp=2", stall_cnt); end
        step;
        req_valid = '0;
        @(negedge clk);
        total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 32'd5}) begin bad++; $display("FAIL skip_rsp2 got=%b/%0d/%0d exp=1/2/5", rsp_valid, rsp_id, rsp_data); end
        step;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL skip_gap got=%b exp=0", rsp_valid); end
        step;
        @(negedge clk);
        total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 32'd7}) begin bad++; $display("FAIL skip_rsp1 got=%b/%0d/%0d exp=1/1/7", rsp_valid, rsp_id, rsp_data); end
        step;
    endtask

    task automatic test_rd0_idle;
        set_req(0, 1, 2, 0, 0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rd0_first got=%b exp=0001", req_ready); end
        step;
        set_req(0, 0, 1, 3, 0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rd0_nostall got=%b exp=0001", req_ready); end
        step;
        req_valid = '0;
        @(negedge clk);
        total++; if ({req_ready, pl_rs1, pl_rs2, pl_rd, pl_func} !== {4'b0000, 5'd0, 5'd0, 5'd0, 4'hF}) begin bad++; $display("FAIL idle_bubble got=%b/%0d/%0d/%0d/%h exp=0000/0/0/0/f", req_ready, pl_rs1, pl_rs2, pl_rd, pl_func); end
        total++; if (pl_addr !== 32'd0) begin bad++; $display("FAIL idle_addr got=%h exp=0", pl_addr); end
        step;
        @(negedge clk);
        total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 32'd5}) begin bad++; $display("FAIL rd0_rsp1 got=%b/%0d/%0d exp=1/0/5", rsp_valid, rsp_id, rsp_data); end
        step;
        @(negedge clk);
        total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 32'd3}) begin bad++; $display("FAIL rd0_rsp2 got=%b/%0d/%0d exp=1/0/3", rsp_valid, rsp_id, rsp_data); end
        step;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL idle_rsp c=%0d got=%b exp=0", c, rsp_valid); end
            step;
        end
        total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL rd0_stall_cnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_reset_midflight;
        set_req(1, 1, 2, 4, 0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rstmf_issue got=%b exp=0010", req_ready); end
        step;
        req_valid = '0;
        set_req(0, 1, 2, 5, 0);
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rstmf_pre_ready got=%b exp=0001", req_ready); end
        #2;
        reset = 1'b1;
        #1;
        total++; if ({req_ready, rsp_valid, stall_cnt} !== {4'b0000, 1'b0, 16'd0}) begin bad++; $display("FAIL rstmf_async got=%b/%b/%0d exp=0000/0/0", req_ready, rsp_valid, stall_cnt); end
        total++; if (pl_func !== 4'hF) begin bad++; $display("FAIL rstmf_bubble got=%h exp=f", pl_func); end
        step;
        reset = 1'b0;
        set_req(2, 1, 2, 6, 0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rstmf_rr_restart got=%b exp=0001", req_ready); end
        step;
        req_valid = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmf_stale_rsp c=%0d got=%b exp=0", c, rsp_valid); end
            step;
        end
        @(negedge clk);
        total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 32'd5}) begin bad++; $display("FAIL rstmf_rsp got=%b/%0d/%0d exp=1/0/5", rsp_valid, rsp_id, rsp_data); end
        step;
    endtask

    initial begin
        test_reset;
        test_single;
        test_raw_stall;
        test_round_robin;
        test_hazard_skip;
        test_rd0_idle;
        test_reset_midflight;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
